multicycle_controller: RTL and testbench

- Sequencing FSM for the multi-cycle RV32I core. Time-shares one ALU, one register-file write port and separate instruction/data memory ports across FETCH, DECODE, EXEC, MEM and WB steps.
- Drives the same datapath select encodings as the single-cycle decoder, adds req/ack memory handshakes, traps (illegal instruction, bus timeout) and a retired-instruction counter.

---
 rtl/rv_ctrl_pkg.sv | 55 +++++
 rtl/multicycle_controller_alu_decoder.sv | 50 +++++
 rtl/multicycle_controller.sv | 228 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32I control path.
//   - Base opcodes (instruction[6:0]) for every supported instruction class
//   - alu_op_e     : ALUctrl encoding understood by the datapath ALU
//   - wb_sel_e     : register-file write-back source select
//   - state_e      : multi-cycle sequencer states
//   - trap_cause_e : reason the sequencer stopped in TRAP
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLTU   = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_PC4 = 2'b00,
        WB_ALU = 2'b01,
        WB_MEM = 2'b10
    } wb_sel_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_e;

    typedef enum logic [1:0] {
        TRAP_NONE    = 2'b00,
        TRAP_ILLEGAL = 2'b01,
        TRAP_IMEM    = 2'b10,
        TRAP_DMEM    = 2'b11
    } trap_cause_e;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: combinational opcode/func3/func7[30] -> ALUctrl decode, shared
// by the single-cycle and multi-cycle controllers.
//   opcode    in  7  instruction[6:0]
//   func3     in  3  instruction[14:12]
//   func7_b30 in  1  instruction[30] (SUB / SRA selector)
//   alu_ctrl  out 4  ALU operation
//   illegal   out 1  unknown opcode or bad use of bit 30
// The remaining func7 bits are checked by the caller.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic       func7_b30,
    output alu_op_e    alu_ctrl,
    output logic       illegal
);

    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        alu_ctrl = ALU_ADD;
        illegal  = 1'b0;
        case (opcode)
            OP_R, OP_I: begin
                case (func3)
                    3'b000:  alu_ctrl = (opcode == OP_R && func7_b30) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_SLTU;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = func7_b30 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
                // Bit 30 is only meaningful for SUB and SRA(I); in OP-IMM it is
                // immediate data except for the shift encodings.
                if (opcode == OP_R && func7_b30 && func3 != 3'b000 && func3 != 3'b101)
                    illegal = 1'b1;
                if (opcode == OP_I && func7_b30 && func3 == 3'b001)
                    illegal = 1'b1;
            end
            OP_LUI:  alu_ctrl = ALU_PASS_B;
            OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC:
                     alu_ctrl = ALU_ADD;
            default: illegal = 1'b1;   // includes opcode[1:0] != 2'b11
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle
// RV32I core, with req/ack memory handshakes, traps and an instret counter.
//   clk, rst                         clock, synchronous active-high reset
//   instruction, b_taken             IR contents, branch comparator result
//   imem_ack, dmem_ack               memory handshake completions
//   imem_req, ir_wr                  instruction fetch request, IR load
//   dmem_req, mem_wr, load_ctrl      data access request, write, func3
//   ALUctrl, A_sel, B_sel            ALU operation and operand selects
//   wb_sel, reg_wr                   write-back source, register write
//   pc_wr, PC_sel                    PC update enable and source
//   halted, trap_cause               TRAP indication and cause
//   instret                          retired-instruction count
module multicycle_controller
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT   = 16,
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instruction,
    input  logic                 b_taken,
    input  logic                 imem_ack,
    input  logic                 dmem_ack,
    output logic                 imem_req,
    output logic                 ir_wr,
    output logic                 dmem_req,
    output logic                 mem_wr,
    output logic [2:0]           load_ctrl,
    output logic [3:0]           ALUctrl,
    output logic                 A_sel,
    output logic                 B_sel,
    output logic [1:0]           wb_sel,
    output logic                 reg_wr,
    output logic                 pc_wr,
    output logic                 PC_sel,
    output logic                 halted,
    output logic [1:0]           trap_cause,
    output logic [INSTRET_W-1:0] instret
);

    localparam int              WAIT_W     = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT - 1);

    state_e                 state, state_nxt;
    trap_cause_e            cause_q, cause_nxt;
    logic [WAIT_W-1:0]      wait_cnt;
    logic [INSTRET_W-1:0]   instret_q;

    logic [6:0] opcode;
    logic [2:0] func3;
    alu_op_e    dec_alu;
    logic       dec_illegal, func7_bad, illegal;
    logic       cls_a_sel, cls_b_sel, is_store;

    assign opcode   = instruction[6:0];
    assign func3    = instruction[14:12];
    assign is_store = (opcode == OP_STORE);

    // Register fields are consumed by the datapath, not by the sequencer.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instruction[24:15], instruction[11:7]};

    alu_decoder u_alu_decoder (
        .opcode    (opcode),
        .func3     (func3),
        .func7_b30 (instruction[30]),
        .alu_ctrl  (dec_alu),
        .illegal   (dec_illegal)
    );

    // Apart from bit 30, func7 must be zero for R-type and for the shift
    // immediates; other OP-IMM encodings carry immediate bits there.
    always_comb begin
        func7_bad = 1'b0;
        if (opcode == OP_R || (opcode == OP_I && func3 inside {3'b001, 3'b101}))
            func7_bad = |{instruction[31], instruction[29:25]};
    end

    assign illegal   = dec_illegal | func7_bad;
    // Operand A is rs1 except for PC-relative classes; B is rs2 only for R-type.
    assign cls_a_sel = opcode inside {OP_R, OP_I, OP_JALR, OP_LOAD, OP_STORE};
    assign cls_b_sel = (opcode != OP_R);

    logic       imem_req_c, ir_wr_c, dmem_req_c, mem_wr_c, reg_wr_c, pc_wr_c, pc_sel_c;
    logic       a_sel_c, b_sel_c, halted_c;
    logic [2:0] load_ctrl_c;
    alu_op_e    alu_c;
    wb_sel_e    wb_c;

    always_comb begin
        state_nxt   = state;
        cause_nxt   = cause_q;
        imem_req_c  = 1'b0;
        ir_wr_c     = 1'b0;
        dmem_req_c  = 1'b0;
        mem_wr_c    = 1'b0;
        reg_wr_c    = 1'b0;
        pc_wr_c     = 1'b0;
        pc_sel_c    = 1'b0;
        a_sel_c     = 1'b0;
        b_sel_c     = 1'b0;
        halted_c    = 1'b0;
        load_ctrl_c = 3'b000;
        alu_c       = ALU_ADD;
        wb_c        = WB_PC4;

        case (state)
            S_FETCH: begin
                imem_req_c = 1'b1;
                // An ack on the limit cycle still completes the fetch.
                if (imem_ack) begin
                    ir_wr_c   = 1'b1;
                    state_nxt = S_DECODE;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    state_nxt = S_TRAP;
                    cause_nxt = TRAP_IMEM;
                end
            end
            S_DECODE: begin
                if (illegal) begin
                    state_nxt = S_TRAP;
                    cause_nxt = TRAP_ILLEGAL;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_c   = dec_alu;
                a_sel_c = cls_a_sel;
                b_sel_c = cls_b_sel;
                case (opcode)
                    OP_JAL, OP_JALR: begin
                        reg_wr_c  = 1'b1;
                        wb_c      = WB_PC4;
                        pc_wr_c   = 1'b1;
                        pc_sel_c  = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    OP_BRANCH: begin
                        pc_wr_c   = 1'b1;
                        pc_sel_c  = b_taken;
                        state_nxt = S_FETCH;
                    end
                    OP_LOAD, OP_STORE: state_nxt = S_MEM;
                    default: begin   // R, I, LUI, AUIPC
                        reg_wr_c  = 1'b1;
                        wb_c      = WB_ALU;
                        pc_wr_c   = 1'b1;
                        state_nxt = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                alu_c       = dec_alu;
                a_sel_c     = cls_a_sel;
                b_sel_c     = cls_b_sel;
                dmem_req_c  = 1'b1;
                mem_wr_c    = is_store;
                load_ctrl_c = func3;
                if (dmem_ack) begin
                    if (is_store) begin
                        pc_wr_c   = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_WB;
                    end
                end else if (wait_cnt == WAIT_LIMIT) begin
                    state_nxt = S_TRAP;
                    cause_nxt = TRAP_DMEM;
                end
            end
            S_WB: begin
                alu_c       = dec_alu;
                a_sel_c     = cls_a_sel;
                b_sel_c     = cls_b_sel;
                load_ctrl_c = func3;
                reg_wr_c    = 1'b1;
                wb_c        = WB_MEM;
                pc_wr_c     = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_TRAP:  halted_c  = 1'b1;
            default: state_nxt = S_TRAP;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            cause_q   <= TRAP_NONE;
            wait_cnt  <= '0;
            instret_q <= '0;
        end else begin
            state   <= state_nxt;
            cause_q <= cause_nxt;
            // Every entry into FETCH or MEM is a state change, so clearing on
            // any transition restarts the handshake timer.
            if (state_nxt != state)
                wait_cnt <= '0;
            else if (state == S_FETCH || state == S_MEM)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (pc_wr_c)
                instret_q <= instret_q + INSTRET_W'(1);
        end
    end

    // Strobes and selects are forced low while reset is asserted, whatever
    // state the register still holds.
    assign imem_req   = imem_req_c & ~rst;
    assign ir_wr      = ir_wr_c    & ~rst;
    assign dmem_req   = dmem_req_c & ~rst;
    assign mem_wr     = mem_wr_c   & ~rst;
    assign reg_wr     = reg_wr_c   & ~rst;
    assign pc_wr      = pc_wr_c    & ~rst;
    assign PC_sel     = pc_sel_c   & ~rst;
    assign A_sel      = a_sel_c    & ~rst;
    assign B_sel      = b_sel_c    & ~rst;
    assign halted     = halted_c   & ~rst;
    assign load_ctrl  = rst ? 3'b000 : load_ctrl_c;
    assign ALUctrl    = rst ? 4'd0   : alu_c;
    assign wb_sel     = rst ? 2'b00  : wb_c;
    assign trap_cause = cause_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Each driven cycle pushes the
// expected output snapshot to a scoreboard; the negedge monitor pops and
// compares it against the DUT outputs of that cycle.
module tb_multicycle_controller;

    localparam int TIMEOUT = 16;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_SUB   = 32'h40208133;
    localparam logic [31:0] I_ADDI  = 32'hFFF00093;
    localparam logic [31:0] I_SRAI  = 32'h4030D093;
    localparam logic [31:0] I_LUI   = 32'h123450B7;
    localparam logic [31:0] I_AUIPC = 32'h00001097;
    localparam logic [31:0] I_JAL   = 32'h008000EF;
    localparam logic [31:0] I_JALR  = 32'h000080E7;
    localparam logic [31:0] I_BEQ   = 32'h00208463;
    localparam logic [31:0] I_LW    = 32'h0000A183;
    localparam logic [31:0] I_SW    = 32'h0020A223;
    localparam logic [31:0] I_MUL   = 32'h02208133;
    localparam logic [31:0] I_BAD   = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst, b_taken, imem_ack, dmem_ack;
    logic [31:0] instruction;
    logic        imem_req, ir_wr, dmem_req, mem_wr, A_sel, B_sel, reg_wr, pc_wr, PC_sel, halted;
    logic [2:0]  load_ctrl;
    logic [3:0]  ALUctrl;
    logic [1:0]  wb_sel, trap_cause;
    logic [31:0] instret;

    always #5 clk = ~clk;

    multicycle_controller #(.TIMEOUT(TIMEOUT), .INSTRET_W(32)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .b_taken(b_taken),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_wr(ir_wr),
        .dmem_req(dmem_req), .mem_wr(mem_wr), .load_ctrl(load_ctrl), .ALUctrl(ALUctrl),
        .A_sel(A_sel), .B_sel(B_sel), .wb_sel(wb_sel), .reg_wr(reg_wr), .pc_wr(pc_wr),
        .PC_sel(PC_sel), .halted(halted), .trap_cause(trap_cause), .instret(instret)
    );

    typedef struct packed {
        logic        imem_req;
        logic        ir_wr;
        logic        dmem_req;
        logic        mem_wr;
        logic [2:0]  load_ctrl;
        logic [3:0]  alu_ctrl;
        logic        a_sel;
        logic        b_sel;
        logic [1:0]  wb_sel;
        logic        reg_wr;
        logic        pc_wr;
        logic        pc_sel;
        logic        halted;
        logic [1:0]  trap_cause;
        logic [31:0] instret;
    } exp_t;

    exp_t  sb[$];
    string tag_q[$];
    int    checks = 0;
    int    failures = 0;
    int    n = 0;                 // model of instret
    logic [1:0] cause_m = 2'b00;  // model of trap_cause
    exp_t  mon_e;
    string mon_t;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t observed();
        exp_t o;
        o = '{imem_req, ir_wr, dmem_req, mem_wr, load_ctrl, ALUctrl, A_sel, B_sel,
              wb_sel, reg_wr, pc_wr, PC_sel, halted, trap_cause, instret};
        return o;
    endfunction

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            mon_t = tag_q.pop_front();
            check(mon_t, 64'(observed()), 64'(mon_e));
        end
    end

    function automatic exp_t ex_base();
        exp_t e;
        e = '0;
        e.instret    = n;
        e.trap_cause = cause_m;
        return e;
    endfunction

    task automatic step(input string tag, input logic r, input logic ia, input logic da,
                        input logic bt, input bit chk, input exp_t e);
        rst = r; imem_ack = ia; dmem_ack = da; b_taken = bt;
        if (chk) begin
            sb.push_back(e);
            tag_q.push_back(tag);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        exp_t e;
        e = ex_base();   // registers still hold pre-reset values this cycle
        step(tag, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, e);
        n = 0;
        cause_m = 2'b00;
    endtask

    task automatic do_fetch(input string tag, input int waits);
        exp_t e;
        for (int i = 0; i < waits; i++) begin
            e = ex_base(); e.imem_req = 1'b1;
            step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e);
        end
        e = ex_base(); e.imem_req = 1'b1; e.ir_wr = 1'b1;
        step(tag, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, e);
    endtask

    // Stray acks in DECODE must be ignored.
    task automatic do_decode(input string tag);
        exp_t e;
        e = ex_base();
        step(tag, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, e);
    endtask

    task automatic do_alu(input string tag, input logic [31:0] w, input int waits,
                          input logic [3:0] alu, input logic a, input logic b);
        exp_t e;
        instruction = w;
        do_fetch({tag, "_fetch"}, waits);
        do_decode({tag, "_dec"});
        e = ex_base(); e.alu_ctrl = alu; e.a_sel = a; e.b_sel = b;
        e.wb_sel = 2'b01; e.reg_wr = 1'b1; e.pc_wr = 1'b1;
        step({tag, "_exec"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e);
        n++;
    endtask

    task automatic do_jump(input string tag, input logic [31:0] w, input logic a);
        exp_t e;
        instruction = w;
        do_fetch({tag, "_fetch"}, 0);
        do_decode({tag, "_dec"});
        e = ex_base(); e.a_sel = a; e.b_sel = 1'b1; e.wb_sel = 2'b00;
        e.reg_wr = 1'b1; e.pc_wr = 1'b1; e.pc_sel = 1'b1;
        step({tag, "_exec"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e);
        n++;
    endtask

    task automatic do_branch(input string tag, input logic bt);
        exp_t e;
        instruction = I_BEQ;
        do_fetch({tag, "_fetch"}, 0);
        do_decode({tag, "_dec"});
        e = ex_base(); e.b_sel = 1'b1; e.pc_wr = 1'b1; e.pc_sel = bt;
        step({tag, "_exec"}, 1'b0, 1'b0, 1'b0, bt, 1'b1, e);
        n++;
    endtask

    // Fetch, decode, EXEC of a load/store; leaves the DUT in its first MEM cycle.
    task automatic to_mem(input string tag, input logic [31:0] w);
        exp_t e;
        instruction = w;
        do_fetch({tag, "_fetch"}, 0);
        do_decode({tag, "_dec"});
        e = ex_base(); e.a_sel = 1'b1; e.b_sel = 1'b1;
        step({tag, "_exec"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e);
    endtask

    function automatic exp_t ex_mem(input logic wr);
        exp_t e;
        e = ex_base(); e.a_sel = 1'b1; e.b_sel = 1'b1; e.dmem_req = 1'b1;
        e.mem_wr = wr; e.load_ctrl = 3'b010;
        return e;
    endfunction

    task automatic do_trap_cycles(input string tag, input int cycles);
        exp_t e;
        for (int i = 0; i < cycles; i++) begin
            e = ex_base(); e.halted = 1'b1;
            step(tag, 1'b0, i[0], i[1], 1'b0, 1'b1, e);
        end
    endtask

    initial begin
        exp_t e;
        instruction = I_ADD;
        step("rst0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        // State is FETCH now, but strobes stay low while rst is held.
        do_reset("rst_hold");

        // ALU class, 3 cycles each.
        do_alu("add", I_ADD, 0, 4'd0, 1'b1, 1'b0);
        do_alu("sub_wait2", I_SUB, 2, 4'd1, 1'b1, 1'b0);
        do_alu("addi_neg", I_ADDI, 0, 4'd0, 1'b1, 1'b1);
        do_alu("srai", I_SRAI, 0, 4'd7, 1'b1, 1'b1);
        do_alu("lui", I_LUI, 0, 4'd10, 1'b0, 1'b1);
        do_alu("auipc", I_AUIPC, 0, 4'd0, 1'b0, 1'b1);
        do_jump("jal", I_JAL, 1'b0);
        do_jump("jalr", I_JALR, 1'b1);
        do_branch("beq_t", 1'b1);
        do_branch("beq_nt", 1'b0);

        // Load with two wait cycles in MEM, then WB.
        to_mem("lw", I_LW);
        step("lw_mem0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ex_mem(1'b0));
        step("lw_mem1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ex_mem(1'b0));
        step("lw_mem2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ex_mem(1'b0));
        e = ex_base(); e.a_sel = 1'b1; e.b_sel = 1'b1; e.load_ctrl = 3'b010;
        e.reg_wr = 1'b1; e.wb_sel = 2'b10; e.pc_wr = 1'b1;
        step("lw_wb", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e);
        n++;

        // Store with immediate ack.
        to_mem("sw", I_SW);
        e = ex_mem(1'b1); e.pc_wr = 1'b1;
        step("sw_mem", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, e);
        n++;
        do_alu("after_sw", I_ADD, 0, 4'd0, 1'b1, 1'b0);

        // Reset in the middle of a store's MEM wait.
        to_mem("sw_rst", I_SW);
        step("sw_rst_mem", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ex_mem(1'b1));
        do_reset("sw_rst_assert");
        e = ex_base(); e.imem_req = 1'b1;
        step("sw_rst_fetch", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e);
        do_fetch("sw_rst_refetch", 0);
        do_decode("sw_rst_dec");
        e = ex_base(); e.wb_sel = 2'b01; e.reg_wr = 1'b1; e.pc_wr = 1'b1; e.a_sel = 1'b1;
        instruction = I_ADD;   // IR contents replaced by the refetch
        step("sw_rst_add", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e);
        n++;

        // Fetch timeout: no ack for TIMEOUT cycles.
        instruction = I_ADD;
        for (int i = 0; i < TIMEOUT; i++) begin
            e = ex_base(); e.imem_req = 1'b1;
            step("imem_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e);
        end
        cause_m = 2'b10;
        do_trap_cycles("imem_trap", 4);
        do_reset("imem_trap_rst");

        // Ack on the limit cycle wins.
        do_alu("ack_at_limit", I_ADD, TIMEOUT - 1, 4'd0, 1'b1, 1'b0);

        // Data timeout on a load.
        to_mem("lw_to", I_LW);
        for (int i = 0; i < TIMEOUT; i++)
            step("dmem_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ex_mem(1'b0));
        cause_m = 2'b11;
        do_trap_cycles("dmem_trap", 3);
        do_reset("dmem_trap_rst");

        // Illegal all-ones word; halted for 20 cycles, then reset.
        instruction = I_BAD;
        do_fetch("bad_fetch", 0);
        do_decode("bad_dec");
        cause_m = 2'b01;
        do_trap_cycles("bad_trap", 20);
        do_reset("bad_trap_rst");

        // Illegal func7 (M extension encoding).
        instruction = I_MUL;
        do_fetch("mul_fetch", 0);
        do_decode("mul_dec");
        cause_m = 2'b01;
        do_trap_cycles("mul_trap", 2);
        do_reset("mul_trap_rst");
        do_alu("final_add", I_ADD, 0, 4'd0, 1'b1, 1'b0);

        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
